// File: rtl/simple_dma_pkg.sv
// Shared types and constants for the simple_dma memory-port initiator.
package simple_dma_pkg;

  localparam int WORD_SHIFT = 5;
  localparam int MAX_LEN    = 127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUF,
    ST_BURST,
    ST_DRAIN,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    STS_OK      = 2'b00,
    STS_ERR     = 2'b01,
    STS_TIMEOUT = 2'b10,
    STS_ILLEGAL = 2'b11
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible on rdata.
// Zero-latency read of the head; pushes when full and pops when empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign do_push = push && (count != CAP);
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/dma_mem_initiator.sv
// Burst initiator for the simple_dma memory port, with write and read data FIFOs around a command FSM.
// Enable rises once the buffers cover the burst; cmd_ready low while busy, wr_ready/rd_valid follow FIFO fill.
module dma_mem_initiator
  import simple_dma_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [6:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        done,
  output logic [1:0]  status,
  output logic        busy,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        m_wenable,
  output logic        m_renable,
  output logic [11:0] m_wsize,
  output logic [11:0] m_rsize,
  input  logic [1:0]  m_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

  state_t      state, state_nxt;
  status_t     fin_sts;
  logic        wr_op;
  logic [6:0]  len, beat;
  logic [1:0]  rd_pipe;
  logic [TW-1:0] tmr;
  logic        accept, start, issue, finish, buf_ok;
  logic [AW:0] wr_count, rd_count, len_ext;
  logic [31:0] wr_head;

  assign accept   = cmd_valid && cmd_ready;
  assign len_ext  = (AW + 1)'(len);
  assign buf_ok   = wr_op ? (wr_count >= len_ext) : ((CAP - rd_count) >= len_ext);
  assign wr_ready = (wr_count != CAP);
  assign rd_valid = (rd_count != '0);

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_valid),
    .wdata (wr_data),
    .pop   (issue && wr_op),
    .rdata (wr_head),
    .count (wr_count)
  );

  // Read beats return two edges after issue; rd_pipe tracks them in flight.
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rd_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rd_pipe[1]),
    .wdata (m_rdata),
    .pop   (rd_ready),
    .rdata (rd_data),
    .count (rd_count)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    fin_sts   = STS_OK;
    unique case (state)
      ST_IDLE:     if (accept && cmd_len != '0) state_nxt = ST_WAIT_BUF;
      ST_WAIT_BUF: if (buf_ok) begin
        state_nxt = ST_BURST;
        start     = 1'b1;
        issue     = 1'b1;
      end
      ST_BURST:    if (beat != len)        issue = 1'b1;
                   else if (rd_pipe == '0) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (m_err[1]) begin
          finish  = 1'b1;
          fin_sts = STS_ERR;
        end else if (m_err[0]) begin
          finish  = 1'b1;
        end else if (tmr == TW'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          fin_sts = STS_TIMEOUT;
        end
        if (finish) state_nxt = ST_GAP;
      end
      ST_GAP:      state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= '0;
      wr_op     <= 1'b0;
      len       <= '0;
      beat      <= '0;
      rd_pipe   <= '0;
      tmr       <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wenable <= 1'b0;
      m_renable <= 1'b0;
      m_wsize   <= '0;
      m_rsize   <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      done      <= 1'b0;
      rd_pipe   <= {rd_pipe[0], issue && !wr_op};
      if (accept) begin
        wr_op  <= cmd_write;
        len    <= cmd_len;
        beat   <= '0;
        tmr    <= '0;
        m_addr <= 32'(cmd_addr) << WORD_SHIFT;
        if (cmd_len == '0) begin
          done   <= 1'b1;
          status <= STS_ILLEGAL;
        end
      end
      if (issue)          beat    <= beat + 7'd1;
      if (issue && wr_op) m_wdata <= wr_head;
      if (start) begin
        m_wenable <= wr_op;
        m_renable <= !wr_op;
        m_wsize   <= wr_op ? (12'(len) << WORD_SHIFT) : '0;
        m_rsize   <= wr_op ? '0 : (12'(len) << WORD_SHIFT);
      end
      if (state == ST_DRAIN) tmr <= tmr + 1'b1;
      if (finish) begin
        done      <= 1'b1;
        status    <= fin_sts;
        m_wenable <= 1'b0;
        m_renable <= 1'b0;
        m_wsize   <= '0;
        m_rsize   <= '0;
      end
    end
  end

endmodule

// File: doc/dma_mem_initiator.md
# dma_mem_initiator

Synthesizable initiator (master) for the simple_dma external memory port. Accepts read/write burst commands from the DMA controller and drives the m_* address/data/enable/size interface toward the memory responder. Buffers write data so every beat is available on time, and buffers read data so the consumer may stall. Reports per-command completion status, including responder error and timeout.

## Interface
- DEPTH, 128: entries in each data FIFO; power of 2, at least 127 (one maximum burst)
- TIMEOUT, 16: cycles to wait for responder completion after the last beat
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both are high at posedge
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  10  start word index
- cmd_len  in  7  burst length in words, legal 1..127
- wr_valid / wr_ready  in / out  1 / 1  write-data stream into the write FIFO
- wr_data  in  32  write word
- rd_valid / rd_ready  out / in  1 / 1  read-data stream out of the read FIFO
- rd_data  out  32  read word (FIFO head)
- done  out  1  one-cycle completion pulse
- status  out  2  valid with done: 00 ok, 01 responder error, 10 timeout, 11 illegal length
- busy  out  1  FSM not in IDLE
- m_addr  out  32  {17'b0, cmd_addr, 5'b0}
- m_wdata  out  32  current write beat
- m_rdata  in  32  read beat from responder
- m_wenable / m_renable  out  1 / 1  burst enables, level, held for the whole burst
- m_wsize / m_rsize  out  12  {cmd_len, 5'b0}; zero when not in use
- m_err  in  2  bit0 completion, bit1 error

## Operation
- Command accepted only in IDLE (cmd_ready = IDLE). Parameters are latched on acceptance.
- cmd_len == 0: no memory access; done with status 11 on the next cycle.
- FSM states and transitions:
  - IDLE -> WAIT_BUF on an accepted, legal command.
  - WAIT_BUF: for a write, wait until write-FIFO count >= len. For a read, wait until read-FIFO free space >= len. Then go to BURST.
  - BURST: assert the enable; run len beats.
  - DRAIN -> GAP.
  - GAP: enable low for exactly one cycle, which guarantees a rising edge for the next burst. Then go to IDLE.
- Write beats: beat i pops the write FIFO and presents the word on m_wdata.
- Read beats: beat i pushes m_rdata into the read FIFO.
- Beat counter is 7 bits, counts 0..len-1.
- DRAIN: keep the enable high and wait for m_err != 0, for at most TIMEOUT cycles.
  - m_err[1] = 1 -> status 01.
  - m_err == 01 -> status 00.
  - TIMEOUT expiry -> status 10.
  - The enable drops and done pulses in the same cycle DRAIN exits.
- A non-zero m_err outside DRAIN is ignored.
- The write FIFO accepts data at any time while not full (wr_ready = !full); it may be preloaded before the command.
- Read data already returned stays in the read FIFO on error or timeout.

## Timing
- Edge k: the enable rises (registered output).
- Write: word 0 is driven on m_wdata from edge k. Word i is valid on m_wdata between edges k+i and k+i+1; the responder samples it at edge k+1+i.
- Read: the initiator captures beat i from m_rdata at edge k+2+i, i = 0..len-1. The last capture is at edge k+1+len.
- Write DRAIN begins at edge k+len. Read DRAIN begins at edge k+2+len.
- Minimum command-accept to done: 1 (WAIT_BUF) + len + drain + 1 cycles.
- Outputs are registered throughout.
- Reset values: cmd_ready 0 during reset and 1 after; all other outputs 0; m_addr/m_wsize/m_rsize 0; both FIFOs empty.
- Reset mid-burst: enables drop at the next edge, no done pulse, FIFOs flushed.
- Simultaneous push and pop on a FIFO keeps the count unchanged.
- Full and empty are exact: no over-write, no under-read.

## Structure
- Shared package simple_dma_pkg holds:
  - FSM state enum
  - status codes
  - WORD_SHIFT = 5
  - MAX_LEN = 127
- One sub-module, sync_fifo (WIDTH, DEPTH), with count output; instantiated twice. Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.

## Test plan
- Preload 4 words A0..A3, write cmd_addr 8, len 4, responder returns m_err = 01 -> memory words 8..11 = A0..A3; m_wsize = 0x080; done with status 00; GAP of one cycle.
- Read cmd_addr 8, len 4, rd_ready held 0 until done -> 4 words queued in order; then drain with rd_ready = 1 -> A0..A3, then rd_valid = 0.
- Write len 127 with only 126 words preloaded -> FSM stays in WAIT_BUF, m_wenable stays 0; the 127th push starts BURST on the next cycle.
- Responder never asserts m_err (TIMEOUT = 16) -> done with status 10 sixteen cycles after DRAIN entry; enable low.
- Responder returns m_err = 10 -> status 01. A separate cmd_len = 0 command -> status 11 with no enable activity.
- rstn low at the third beat of a len-8 read -> enables 0 and FIFOs empty after the edge, no done; a new command after reset completes normally.
